uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter for the SoC UART subsystem. It combines a configurable-depth transmit FIFO with a frame serialiser. Over the previous fixed 8-bit/16-deep design it adds:
- generic character width and oversample ratio
- odd/even parity select and 1 or 2 stop bits
- FIFO fill-level and overflow reporting, and a frame-done pulse

It sits between the APB UART register block and the pad.

Parameters:
DATA_W, 8, character width in bits, legal 5..9
FIFO_DEPTH, 16, transmit FIFO entries, power of 2, 4..256
OVERSAMPLE, 16, en_baud_i ticks per bit period, legal 4..32
AFULL_TH, 12, buffer_afull_o asserts when level >= AFULL_TH
AEMPTY_TH, 4, buffer_aempty_o asserts when level <= AEMPTY_TH

Ports:
clk  input  1  single clock; sole clock of the block
rst  input  1  synchronous reset, active high
msb_first_i  input  1  0: LSB first; 1: MSB first
parity_en_i  input  1  1: append parity bit
parity_odd_i  input  1  0: even parity; 1: odd parity
stop2_i  input  1  0: one stop bit; 1: two stop bits
start_polarity_i  input  1  0: low start bit, high stop/idle; 1: inverted
data_in_i  input  DATA_W  character to enqueue
write_buffer_i  input  1  enqueue strobe, active high
reset_buffer_i  input  1  FIFO flush, active high
en_baud_i  input  1  oversample tick, one clk wide
serial_out_o  output  1  serial line
busy_o  output  1  frame in progress (state != IDLE)
tx_done_o  output  1  one-cycle pulse at end of last stop bit
overflow_o  output  1  one-cycle pulse when a write is dropped because the FIFO is full
buffer_full_o  output  1  level == FIFO_DEPTH
buffer_empty_o  output  1  level == 0
buffer_afull_o  output  1  level >= AFULL_TH
buffer_aempty_o  output  1  level <= AEMPTY_TH
level_o  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- All state updates on rising edge of clk. rst is synchronous and active high.
- Reset values:
  - level_o=0, buffer_empty_o=1, buffer_aempty_o=1
  - buffer_full_o=0, buffer_afull_o=0
  - busy_o=0, tx_done_o=0, overflow_o=0
  - serial_out_o=1; FSM=IDLE
- FIFO:
  - Write accepted when write_buffer_i=1 and not full; level visible the next cycle.
  - Write while full: data dropped, overflow_o pulses the next cycle.
  - Simultaneous push and pop with level>0: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- reset_buffer_i: clears level and pointers next cycle and beats a same-cycle write, which is dropped with no overflow. It does not abort a frame in flight.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - serial_out_o = ~start_polarity_i (registered).
  - On the first en_baud_i with FIFO non-empty: pop the head into the shift register and latch all configuration inputs (msb_first_i, parity_en_i, parity_odd_i, stop2_i, start_polarity_i) for the whole frame; go to START.
  - Configuration changes mid-frame have no effect.
- Bit timing: each bit is held for exactly OVERSAMPLE en_baud_i ticks. A tick counter counts 0..OVERSAMPLE-1. serial_out_o updates the cycle after the tick that completes the previous bit.
- START: drive start_polarity_i.
- DATA: shift DATA_W bits, LSB first or MSB first as latched. Data bits are transmitted true and are not affected by polarity.
- PARITY (only if parity_en latched): even = XOR of the data bits; odd = inverted XOR.
- STOP: drive ~start_polarity; duration 1 or 2 bit periods.
  - tx_done_o pulses on the cycle the last stop bit completes; FSM returns to IDLE.
  - If the FIFO is non-empty on the same tick, the pop happens on that tick and START follows with no idle gap (back-to-back frames).
- en_baud_i held low: FSM and counters freeze; serial_out_o holds its level.
- rst mid-frame: frame abandoned, FIFO cleared, outputs take their reset values the next cycle.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input break_i.
- When break_i=1 and FSM=IDLE, the line enters BREAK state and drives start_polarity_i continuously; no FIFO pop occurs.
- On break_i=0, the line drives stop level for one full bit period (OVERSAMPLE ticks) before the FSM may return to IDLE.
- break_i asserted mid-frame takes effect only after that frame's STOP.
- Undefined: port and state absent; behaviour as above.

Test Plan:
- OVERSAMPLE=16, en_baud_i every cycle, 8N1 LSB first, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 with each bit 16 clocks wide; tx_done_o pulses once; frame lasts 160 clocks.
- 0xA5, parity_en_i=1: parity_odd_i=0 -> parity bit 0; parity_odd_i=1 -> parity bit 1. With stop2_i=1 the stop level is held 32 clocks.
- Write 17 characters into an empty FIFO with FIFO_DEPTH=16 and en_baud_i=0 -> level_o=16, buffer_full_o=1, one overflow_o pulse, the 17th character never transmitted.
- Write 3 characters back-to-back, then enable en_baud_i -> three contiguous frames with no idle gap; level_o 3->2->1->0; buffer_empty_o=1 after the third pop.
- start_polarity_i=1, msb_first_i=1, 0x81 -> idle 0, start 1, data 1,0,0,0,0,0,0,1, stop 0. Toggling msb_first_i mid-frame does not change the frame.
- reset_buffer_i during frame 1 of 4 queued -> frame 1 completes; level_o=0 next cycle; no further frames. A same-cycle write is dropped with no overflow_o.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: transmit FIFO feeding a start/data/parity/stop serialiser.
// Define UART_TX_BREAK_EN to add break_i and line-break generation.
//
// state      | meaning
// S_IDLE     | line at stop level, waiting for a tick with FIFO data
// S_START    | start bit
// S_DATA     | DATA_W data bits
// S_PARITY   | parity bit (frame latched with parity enabled)
// S_STOP     | one or two stop bits
// S_BREAK    | break: line held at start level while break_i=1
// S_BRK_STOP | one stop-level bit period after a break
module uart_tx_param #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16,
   parameter int AFULL_TH   = 12,
   parameter int AEMPTY_TH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          msb_first_i,
   input  logic                          parity_en_i,
   input  logic                          parity_odd_i,
   input  logic                          stop2_i,
   input  logic                          start_polarity_i,
   input  logic [DATA_W-1:0]             data_in_i,
   input  logic                          write_buffer_i,
   input  logic                          reset_buffer_i,
`ifdef UART_TX_BREAK_EN
   input  logic                          break_i,
`endif
   input  logic                          en_baud_i,
   output logic                          serial_out_o,
   output logic                          busy_o,
   output logic                          tx_done_o,
   output logic                          overflow_o,
   output logic                          buffer_full_o,
   output logic                          buffer_empty_o,
   output logic                          buffer_afull_o,
   output logic                          buffer_aempty_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_TH);
   localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_TH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
      , S_BREAK, S_BRK_STOP
`endif
   } state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level;
   logic              full, empty, push, pop, overflow;
   logic [DATA_W-1:0] head;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              stop_idx;
   logic [DATA_W-1:0] shreg;
   logic              par_bit, frame_par_en, frame_stop2, frame_pol;
   logic              serial, tx_done;
   logic              bit_end, stop_last, brk_req;

`ifdef UART_TX_BREAK_EN
   assign brk_req = break_i;
`else
   assign brk_req = 1'b0;
`endif

   function automatic logic [DATA_W-1:0] reverse_bits(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      return r;
   endfunction

   assign full      = (level == DEPTH_L);
   assign empty     = (level == '0);
   assign head      = mem[rd_ptr];
   assign push      = write_buffer_i && !full && !reset_buffer_i;
   assign bit_end   = en_baud_i && (cnt == CNT_LAST);
   assign stop_last = !frame_stop2 || stop_idx;
   // A pop starts a frame, either from idle or straight out of the final stop bit
   assign pop = en_baud_i && !empty && !reset_buffer_i && !brk_req &&
                ((state == S_IDLE) || (state == S_STOP && bit_end && stop_last));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= write_buffer_i && full && !reset_buffer_i;
         if (reset_buffer_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   level <= level + LVL_W'(1);
               2'b01:   level <= level - LVL_W'(1);
               default: level <= level;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         idx          <= '0;
         stop_idx     <= 1'b0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         frame_par_en <= 1'b0;
         frame_stop2  <= 1'b0;
         frame_pol    <= 1'b0;
         serial       <= 1'b1;
         tx_done      <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (en_baud_i) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
         case (state)
            S_IDLE: begin
               cnt    <= '0;
               serial <= ~start_polarity_i;
`ifdef UART_TX_BREAK_EN
               if (break_i) begin
                  state  <= S_BREAK;
                  serial <= start_polarity_i;
               end
`endif
            end
            S_START: if (bit_end) begin
               state  <= S_DATA;
               idx    <= '0;
               serial <= shreg[0];
            end
            S_DATA: if (bit_end) begin
               if (idx == IDX_LAST) begin
                  if (frame_par_en) begin
                     state  <= S_PARITY;
                     serial <= par_bit;
                  end else begin
                     state    <= S_STOP;
                     stop_idx <= 1'b0;
                     serial   <= ~frame_pol;
                  end
               end else begin
                  idx    <= idx + IDX_W'(1);
                  shreg  <= shreg >> 1;
                  serial <= shreg[1];
               end
            end
            S_PARITY: if (bit_end) begin
               state    <= S_STOP;
               stop_idx <= 1'b0;
               serial   <= ~frame_pol;
            end
            S_STOP: if (bit_end) begin
               if (!stop_last) begin
                  stop_idx <= 1'b1;
               end else begin
                  tx_done <= 1'b1;
                  state   <= S_IDLE;
                  serial  <= ~start_polarity_i;
               end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
               cnt <= '0;
               if (break_i) begin
                  serial <= start_polarity_i;
               end else begin
                  serial <= ~start_polarity_i;
                  state  <= S_BRK_STOP;
               end
            end
            S_BRK_STOP: begin
               serial <= ~start_polarity_i;
               if (bit_end) state <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
         // Frame load overrides the per-state updates; MSB-first is folded into the load
         if (pop) begin
            state        <= S_START;
            cnt          <= '0;
            shreg        <= msb_first_i ? reverse_bits(head) : head;
            par_bit      <= (^head) ^ parity_odd_i;
            frame_par_en <= parity_en_i;
            frame_stop2  <= stop2_i;
            frame_pol    <= start_polarity_i;
            serial       <= start_polarity_i;
         end
      end
   end

   assign serial_out_o    = serial;
   assign busy_o          = (state != S_IDLE);
   assign tx_done_o       = tx_done;
   assign overflow_o      = overflow;
   assign buffer_full_o   = full;
   assign buffer_empty_o  = empty;
   assign buffer_afull_o  = (level >= AFULL_L);
   assign buffer_aempty_o = (level <= AEMPTY_L);
   assign level_o         = level;

endmodule
